// File: rtl/alu_sequencer.sv
// alu_sequencer: decodes 16-bit instructions and sequences them onto an
// external register file. It takes one instruction at a time and reports
// READ results through a valid/ready handshake.
//   clk, reset (async, active-low)
//   instr/instr_valid/instr_ready : instruction input handshake
//   addr_a/addr_b/addr_r/data_in/op : register-file command (all registered)
//   alu_data_out : register-file read data
//   rd_data/rd_valid/rd_ready : read result output handshake
//   busy : high whenever the sequencer is not IDLE
// Parameter READ_LATENCY (1..7): cycles from REG_READ issue to capture.

package constants_pkg;
  typedef enum logic [1:0] {
    REG_READ  = 2'd0,
    REG_WRITE = 2'd1,
    ADD       = 2'd2
  } ALUOp;
endpackage

module alu_sequencer
  import constants_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic [2:0]          addr_a,
  output logic [2:0]          addr_b,
  output logic [2:0]          addr_r,
  output logic [7:0]          data_in,
  output constants_pkg::ALUOp op,
  input  logic [7:0]          alu_data_out,
  output logic [7:0]          rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESULT  = 2'd3
  } state_t;

  localparam logic [1:0] OPC_NOP   = 2'b00;
  localparam logic [1:0] OPC_WRITE = 2'b01;
  localparam logic [1:0] OPC_ADD   = 2'b10;
  localparam logic [1:0] OPC_READ  = 2'b11;

  localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

  state_t     r_state;
  logic [1:0] r_opc;
  logic [2:0] r_cnt;

  logic       w_accept;
  logic [1:0] w_opc;
  logic [2:0] w_rd;
  logic [2:0] w_ra;
  logic [2:0] w_rb;
  logic [7:0] w_imm;

  // instr_ready is only ever high in IDLE, so accept implies IDLE.
  assign w_accept = instr_valid && instr_ready;
  assign w_opc    = instr[15:14];
  assign w_rd     = instr[13:11];
  assign w_ra     = instr[10:8];
  assign w_rb     = instr[7:5];
  assign w_imm    = instr[7:0];

  // Sequencer FSM; all outputs are registered and computed for the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_opc       <= OPC_NOP;
      r_cnt       <= 3'd0;
      instr_ready <= 1'b0;
      busy        <= 1'b0;
      op          <= REG_READ;
      addr_a      <= 3'd0;
      addr_b      <= 3'd0;
      addr_r      <= 3'd0;
      data_in     <= 8'd0;
      rd_data     <= 8'd0;
      rd_valid    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // NOPs are consumed without leaving IDLE or touching the register file.
          if (w_accept && (w_opc != OPC_NOP)) begin
            r_state     <= ISSUE;
            r_opc       <= w_opc;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            case (w_opc)
              OPC_WRITE: begin
                op      <= REG_WRITE;
                addr_a  <= w_rd;
                data_in <= w_imm;
              end
              OPC_ADD: begin
                op     <= ADD;
                addr_a <= w_ra;
                addr_b <= w_rb;
                addr_r <= w_rd;
              end
              default: begin
                op     <= REG_READ;
                addr_a <= w_ra;
              end
            endcase
          end else begin
            instr_ready <= 1'b1;
            busy        <= 1'b0;
          end
        end

        ISSUE: begin
          if (r_opc == OPC_READ) begin
            // Keep REG_READ/addr_a driven while the read data settles.
            r_state <= WAIT_RD;
            r_cnt   <= LAT_LOAD;
          end else begin
            r_state     <= IDLE;
            op          <= REG_READ;
            addr_a      <= 3'd0;
            addr_b      <= 3'd0;
            addr_r      <= 3'd0;
            data_in     <= 8'd0;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
          end
        end

        WAIT_RD: begin
          if (r_cnt == 3'd0) begin
            rd_data  <= alu_data_out;
            rd_valid <= 1'b1;
            r_state  <= RESULT;
            addr_a   <= 3'd0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end

        RESULT: begin
          if (rd_ready) begin
            rd_valid    <= 1'b0;
            r_state     <= IDLE;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
          end else begin
            rd_valid <= 1'b1;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_cnt       <= 3'd0;
          instr_ready <= 1'b0;
          busy        <= 1'b0;
          op          <= REG_READ;
          addr_a      <= 3'd0;
          addr_b      <= 3'd0;
          addr_r      <= 3'd0;
          data_in     <= 8'd0;
          rd_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer. Two instances share clk/reset:
// u_dut (READ_LATENCY=1) runs the main directed sequence, u_dut3
// (READ_LATENCY=3) checks the longer read timing. Each instance drives a
// simple register-file model with a one-cycle registered read port.
module tb_alu_sequencer;
  import constants_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  addr_a, addr_b, addr_r;
  logic [7:0]  data_in;
  ALUOp        op;
  logic [7:0]  alu_data_out;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        busy;

  logic [15:0] instr3;
  logic        instr_valid3;
  logic        instr_ready3;
  logic [2:0]  addr_a3, addr_b3, addr_r3;
  logic [7:0]  data_in3;
  ALUOp        op3;
  logic [7:0]  alu_data_out3;
  logic [7:0]  rd_data3;
  logic        rd_valid3;
  logic        rd_ready3;
  logic        busy3;

  alu_sequencer #(.READ_LATENCY(1)) u_dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .addr_a(addr_a), .addr_b(addr_b), .addr_r(addr_r),
    .data_in(data_in), .op(op), .alu_data_out(alu_data_out), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .busy(busy)
  );

  alu_sequencer #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .instr(instr3), .instr_valid(instr_valid3),
    .instr_ready(instr_ready3), .addr_a(addr_a3), .addr_b(addr_b3), .addr_r(addr_r3),
    .data_in(data_in3), .op(op3), .alu_data_out(alu_data_out3), .rd_data(rd_data3),
    .rd_valid(rd_valid3), .rd_ready(rd_ready3), .busy(busy3)
  );

  // Register-file models (not reset: they are external storage).
  logic [7:0] mem  [8];
  logic [7:0] mem3 [8];

  always @(posedge clk) begin
    case (op)
      REG_WRITE: mem[addr_a] <= data_in;
      ADD:       mem[addr_r] <= mem[addr_a] + mem[addr_b];
      default:   ;
    endcase
    alu_data_out <= mem[addr_a];
  end

  always @(posedge clk) begin
    case (op3)
      REG_WRITE: mem3[addr_a3] <= data_in3;
      ADD:       mem3[addr_r3] <= mem3[addr_a3] + mem3[addr_b3];
      default:   ;
    endcase
    alu_data_out3 <= mem3[addr_a3];
  end

  // A write or add must never be issued while a result is being presented.
  int n_viol = 0;
  always @(negedge clk) begin
    if ((rd_valid && (op != REG_READ)) || (rd_valid3 && (op3 != REG_READ)))
      n_viol++;
  end

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] wr_i(input logic [2:0] rd, input logic [7:0] imm);
    return {2'b01, rd, 3'b000, imm};
  endfunction

  function automatic logic [15:0] add_i(input logic [2:0] rd, input logic [2:0] ra,
                                        input logic [2:0] rb);
    return {2'b10, rd, ra, rb, 5'b00000};
  endfunction

  function automatic logic [15:0] rd_i(input logic [2:0] ra);
    return {2'b11, 3'b000, ra, 8'h00};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [15:0] w);
    int t = 0;
    while (instr_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready", {31'd0, instr_ready}, 32'd1);
    instr       = w;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 16'h0000;
  endtask

  // READ with expected data from the scoreboard; optionally stall rd_ready
  // for 'hold' cycles while trying to inject a WRITE r2=0xFF.
  task automatic do_read(input logic [2:0] ra, input int hold);
    int t = 0;
    logic [7:0] e;
    send(rd_i(ra));
    while (rd_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("rd_latency", t, 32'd2);
    e = sb.pop_front();
    chk("rd_data", {24'd0, rd_data}, {24'd0, e});
    chk("rd_busy", {31'd0, busy}, 32'd1);
    if (hold > 0) begin
      instr       = wr_i(3'd2, 8'hFF);
      instr_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", {31'd0, rd_valid}, 32'd1);
        chk("hold_data", {24'd0, rd_data}, {24'd0, e});
        chk("hold_ready", {31'd0, instr_ready}, 32'd0);
        chk("hold_op", {30'd0, op}, {30'd0, REG_READ});
      end
      instr_valid = 1'b0;
      instr       = 16'h0000;
    end
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
    chk("rd_release", {31'd0, rd_valid}, 32'd0);
    chk("rd_idle_ready", {31'd0, instr_ready}, 32'd1);
  endtask

  task automatic read_exp(input logic [2:0] ra, input logic [7:0] exp, input int hold);
    sb.push_back(exp);
    do_read(ra, hold);
  endtask

  initial begin
    int t;
    instr = 16'h0000;  instr_valid = 1'b0;  rd_ready = 1'b0;
    instr3 = 16'h0000; instr_valid3 = 1'b0; rd_ready3 = 1'b0;

    // Reset state
    #22;
    chk("rst_ready", {31'd0, instr_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_op", {30'd0, op}, {30'd0, REG_READ});
    chk("rst_addr", {23'd0, addr_a, addr_b, addr_r}, 32'd0);
    chk("rst_din", {24'd0, data_in}, 32'd0);
    chk("rst_rd", {23'd0, rd_valid, rd_data}, 32'd0);
    chk("rst_ready3", {31'd0, instr_ready3}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);

    // NOP: no state change, no access
    send(16'h0000);
    chk("nop_busy", {31'd0, busy}, 32'd0);
    chk("nop_ready", {31'd0, instr_ready}, 32'd1);
    chk("nop_op", {30'd0, op}, {30'd0, REG_READ});

    // WRITE r0=0x42 with ISSUE cycle detail and 2-cycle throughput
    send(wr_i(3'd0, 8'h42));
    chk("wr_op", {30'd0, op}, {30'd0, REG_WRITE});
    chk("wr_addr", {29'd0, addr_a}, 32'd0);
    chk("wr_din", {24'd0, data_in}, 32'h42);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    chk("wr_ready", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    chk("wr_done_op", {30'd0, op}, {30'd0, REG_READ});
    chk("wr_done_din", {24'd0, data_in}, 32'd0);
    chk("wr_done_ready", {31'd0, instr_ready}, 32'd1);

    send(wr_i(3'd1, 8'h24));
    @(negedge clk);
    send(add_i(3'd2, 3'd0, 3'd1));
    chk("add_op", {30'd0, op}, {30'd0, ADD});
    chk("add_addr", {23'd0, addr_a, addr_b, addr_r}, {23'd0, 3'd0, 3'd1, 3'd2});
    @(negedge clk);
    chk("add_done_addr", {23'd0, addr_a, addr_b, addr_r}, 32'd0);

    // READ r2 with consumer stalled 10 cycles and an ignored WRITE attempt
    read_exp(3'd2, 8'h66, 10);
    read_exp(3'd2, 8'h66, 0);

    // Fibonacci
    send(wr_i(3'd0, 8'h00));
    send(wr_i(3'd1, 8'h01));
    send(wr_i(3'd2, 8'h01));
    for (int r = 3; r < 8; r++)
      send(add_i(3'(r), 3'(r - 1), 3'(r - 2)));
    read_exp(3'd0, 8'h00, 0);
    read_exp(3'd1, 8'h01, 0);
    read_exp(3'd2, 8'h01, 0);
    read_exp(3'd3, 8'h02, 0);
    read_exp(3'd4, 8'h03, 0);
    read_exp(3'd5, 8'h05, 0);
    read_exp(3'd6, 8'h08, 0);
    read_exp(3'd7, 8'h0D, 0);

    // Wrap-around add
    send(wr_i(3'd0, 8'hF0));
    send(wr_i(3'd1, 8'h20));
    send(add_i(3'd2, 3'd0, 3'd1));
    read_exp(3'd2, 8'h10, 0);

    // Reset during WAIT_RD
    send(rd_i(3'd2));
    @(negedge clk);
    chk("wait_busy", {31'd0, busy}, 32'd1);
    chk("wait_addr", {29'd0, addr_a}, 32'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_ready", {31'd0, instr_ready}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_rd", {23'd0, rd_valid, rd_data}, 32'd0);
    chk("arst_addr", {23'd0, addr_a, addr_b, addr_r}, 32'd0);
    chk("arst_op", {30'd0, op}, {30'd0, REG_READ});
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("arst_no_result", {31'd0, rd_valid}, 32'd0);
    end
    read_exp(3'd2, 8'h10, 0);

    // READ_LATENCY=3 instance
    @(negedge clk);
    chk("l3_ready", {31'd0, instr_ready3}, 32'd1);
    instr3 = wr_i(3'd1, 8'h5A);
    instr_valid3 = 1'b1;
    @(negedge clk);
    instr_valid3 = 1'b0;
    chk("l3_wr_op", {30'd0, op3}, {30'd0, REG_WRITE});
    @(negedge clk);
    instr3 = rd_i(3'd1);
    instr_valid3 = 1'b1;
    @(negedge clk);
    instr_valid3 = 1'b0;
    t = 0;
    while (rd_valid3 !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("l3_latency", t, 32'd4);
    chk("l3_data", {24'd0, rd_data3}, 32'h5A);
    rd_ready3 = 1'b1;
    @(negedge clk);
    rd_ready3 = 1'b0;
    chk("l3_release", {31'd0, rd_valid3}, 32'd0);

    chk("no_write_while_rd_valid", n_viol, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
